reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 116 +++++++++++
 tb/tb_reg_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// Register bank with two combinational read ports, one write port and a clear sweep.
// Optional write-to-read bypass is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned INIT_MODE = 1,
    parameter int unsigned ZERO_REG  = 0,
    parameter int unsigned DBG_IDX   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd1_sel,
    input  logic [ADDR_W-1:0] rd2_sel,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              ready,
    output logic              wr_drop,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned       DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DBG_SEL = ADDR_W'(DBG_IDX);

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_drop_q, drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              zero_wr, wr_en;
    logic [DATA_W-1:0] clr_val;
`ifdef REG_BANK_BYPASS_EN
    logic              byp_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == '1) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        ready   = (state_q == StReady);
        zero_wr = (ZERO_REG != 0) && (wr_sel == '0);
        wr_en   = ready && we && !clr_req && !zero_wr;
        // Writes into a hardwired-zero entry are silently ignored, never flagged.
        drop_d  = we && !zero_wr && (!ready || clr_req);
        clr_val = (INIT_MODE == 1) ? DATA_W'(ptr_q) : '0;
`ifdef REG_BANK_BYPASS_EN
        byp_en  = ready && we;
`endif
    end

    // Storage is not reset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StClear) begin
                mem_q[ptr_q] <= clr_val;
            end else if (wr_en) begin
                mem_q[wr_sel] <= wr_data;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] val;
        val = mem_q[sel];
`ifdef REG_BANK_BYPASS_EN
        if (byp_en && (sel == wr_sel)) begin
            val = wr_data;
        end
`endif
        if (!ready || ((ZERO_REG != 0) && (sel == '0))) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        rd1_data = read_port(rd1_sel);
        rd2_data = read_port(rd2_sel);
    end

    assign wr_drop  = wr_drop_q;
    assign dbg_data = mem_q[DBG_SEL];

endmodule

// File: tb/tb_reg_bank.sv
// Randomized bench for reg_bank: a default instance and a small ZERO_REG/INIT_MODE=0 instance,
// both checked every cycle against an array-based reference model.
module tb_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        we  [2];
    logic        clr [2];
    logic [4:0]  rs1 [2];
    logic [4:0]  rs2 [2];
    logic [4:0]  ws  [2];
    logic [31:0] wd  [2];

    logic [31:0] r1_b, r2_b, dbg_b;
    logic        rdy_b, drp_b;
    logic [15:0] r1_s, r2_s, dbg_s;
    logic        rdy_s, drp_s;

    reg_bank u_big (
        .clk      (clk),
        .rst      (rst),
        .rd1_sel  (rs1[0]),
        .rd2_sel  (rs2[0]),
        .rd1_data (r1_b),
        .rd2_data (r2_b),
        .we       (we[0]),
        .wr_sel   (ws[0]),
        .wr_data  (wd[0]),
        .clr_req  (clr[0]),
        .ready    (rdy_b),
        .wr_drop  (drp_b),
        .dbg_data (dbg_b)
    );

    reg_bank #(
        .DATA_W    (16),
        .ADDR_W    (3),
        .INIT_MODE (0),
        .ZERO_REG  (1),
        .DBG_IDX   (3)
    ) u_small (
        .clk      (clk),
        .rst      (rst),
        .rd1_sel  (rs1[1][2:0]),
        .rd2_sel  (rs2[1][2:0]),
        .rd1_data (r1_s),
        .rd2_data (r2_s),
        .we       (we[1]),
        .wr_sel   (ws[1][2:0]),
        .wr_data  (wd[1][15:0]),
        .clr_req  (clr[1]),
        .ready    (rdy_s),
        .wr_drop  (drp_s),
        .dbg_data (dbg_s)
    );

    int          n_total;
    int          n_bad;
    int          depth [2] = '{32, 8};
    int          zr    [2] = '{0, 1};
    int          imode [2] = '{1, 0};
    logic [31:0] mask  [2] = '{32'hffff_ffff, 32'h0000_ffff};
    logic [31:0] mem   [2][32];
    int          left  [2];   // sweep cycles still to run; 0 means accepting
    logic        drop  [2];
    bit          swept [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int m, input logic [4:0] sel_raw);
        int sel;
        sel = int'(sel_raw) % depth[m];
        if (left[m] != 0) return 32'h0;
        if (zr[m] != 0 && sel == 0) return 32'h0;
`ifdef REG_BANK_BYPASS_EN
        if (we[m] && sel == int'(ws[m]) % depth[m]) return wd[m] & mask[m];
`endif
        return mem[m][sel];
    endfunction

    task automatic check_outputs();
        check("b_rd1", r1_b, exp_rd(0, rs1[0]));
        check("b_rd2", r2_b, exp_rd(0, rs2[0]));
        check("b_ready", 32'(rdy_b), (left[0] == 0) ? 32'd1 : 32'd0);
        check("b_drop", 32'(drp_b), 32'(drop[0]));
        if (swept[0]) check("b_dbg", dbg_b, mem[0][3]);
        check("s_rd1", {16'h0, r1_s}, exp_rd(1, rs1[1]));
        check("s_rd2", {16'h0, r2_s}, exp_rd(1, rs2[1]));
        check("s_ready", 32'(rdy_s), (left[1] == 0) ? 32'd1 : 32'd0);
        check("s_drop", 32'(drp_s), 32'(drop[1]));
        if (swept[1]) check("s_dbg", {16'h0, dbg_s}, mem[1][3]);
    endtask

    task automatic update_model();
        for (int m = 0; m < 2; m++) begin
            int  wsel;
            bit  zhit;
            wsel = int'(ws[m]) % depth[m];
            zhit = (zr[m] != 0) && (wsel == 0);
            if (rst) begin
                left[m] = depth[m];
                drop[m] = 1'b0;
            end else if (left[m] > 0) begin
                int idx;
                idx = depth[m] - left[m];
                mem[m][idx] = (imode[m] == 1) ? (32'(idx) & mask[m]) : 32'h0;
                left[m]--;
                if (left[m] == 0) swept[m] = 1'b1;
                drop[m] = we[m] && !zhit;
            end else if (clr[m]) begin
                left[m] = depth[m];
                drop[m] = we[m] && !zhit;
            end else begin
                drop[m] = 1'b0;
                if (we[m] && !zhit) mem[m][wsel] = wd[m] & mask[m];
            end
        end
    endtask

    // Entered and left just after a falling edge with inputs already applied.
    task automatic do_cycle();
        #1;
        check_outputs();
        update_model();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            we[m] = 1'b0; clr[m] = 1'b0;
            rs1[m] = '0; rs2[m] = '0; ws[m] = '0; wd[m] = '0;
        end
    endtask

    task automatic rand_inputs();
        rst = ($urandom_range(0, 299) == 0);
        for (int m = 0; m < 2; m++) begin
            we[m]  = 1'($urandom_range(0, 1));
            clr[m] = ($urandom_range(0, 39) == 0);
            ws[m]  = 5'($urandom);
            wd[m]  = $urandom;
            rs1[m] = ($urandom_range(0, 3) == 0) ? ws[m] : 5'($urandom);
            rs2[m] = ($urandom_range(0, 3) == 0) ? ws[m] : 5'($urandom);
        end
    endtask

    initial begin
        int lat_b;
        int lat_s;
        int cnt;
        n_total = 0;
        n_bad   = 0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            left[m] = depth[m]; drop[m] = 1'b0; swept[m] = 1'b0;
        end

        // Ready latency after a one-cycle reset pulse.
        lat_b = -1;
        lat_s = -1;
        for (int c = 0; c < 40; c++) begin
            if (lat_b < 0 && rdy_b) lat_b = c;
            if (lat_s < 0 && rdy_s) lat_s = c;
            do_cycle();
        end
        check("lat_big", 32'(lat_b), 32'd32);
        check("lat_small", 32'(lat_s), 32'd8);
        rs1[0] = 5'd7;
        #1;
        check("rd7", r1_b, 32'd7);
        check("dbg_big", dbg_b, 32'd3);
        check("dbg_small", {16'h0, dbg_s}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rs1[1] = 5'(i);
            #1;
            check("small_clr", {16'h0, r1_s}, 32'd0);
        end
        rs1[1] = '0;

        // Write to entry 5 with a same-cycle read.
        we[0] = 1'b1; ws[0] = 5'd5; wd[0] = 32'hDEAD_BEEF; rs2[0] = 5'd5;
        #1;
`ifdef REG_BANK_BYPASS_EN
        check("wr5_same", r2_b, 32'hDEAD_BEEF);
`else
        check("wr5_same", r2_b, 32'd5);
`endif
        do_cycle();
        we[0] = 1'b0;
        #1;
        check("wr5_next", r2_b, 32'hDEAD_BEEF);

        // Write just after a clear request is dropped.
        clr[0] = 1'b1;
        do_cycle();
        clr[0] = 1'b0; we[0] = 1'b1; ws[0] = 5'd9; wd[0] = 32'h5555_AAAA;
        do_cycle();
        we[0] = 1'b0;
        #1;
        check("drop9", 32'(drp_b), 32'd1);
        do_cycle();
        #1;
        check("drop9_end", 32'(drp_b), 32'd0);
        cnt = 0;
        while (!rdy_b && cnt < 100) begin
            do_cycle();
            cnt++;
        end
        rs1[0] = 5'd9;
        #1;
        check("rd9", r1_b, 32'd9);

        // Hardwired-zero entry on the small instance.
        we[1] = 1'b1; ws[1] = 5'd0; wd[1] = 32'h1234; rs1[1] = 5'd0;
        do_cycle();
        we[1] = 1'b0;
        #1;
        check("zr_rd", {16'h0, r1_s}, 32'd0);
        check("zr_drop", 32'(drp_s), 32'd0);

        // Reset in the middle of a sweep restarts it.
        clr[0] = 1'b1;
        do_cycle();
        clr[0] = 1'b0;
        repeat (20) do_cycle();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        cnt = 0;
        while (!rdy_b && cnt < 100) begin
            do_cycle();
            cnt++;
        end
        check("rst_mid_lat", 32'(cnt), 32'd32);

        repeat (3000) begin
            rand_inputs();
            do_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
